// File: rtl/endpoint_ctrl.sv
// endpoint_ctrl
//   Control/status register block for the chiplet endpoint.
//   - Per-message packet start addresses (pkt_start[i]) into the TX cache.
//   - Queued send mechanism: host writes message ids into a circular FIFO,
//     which the TX FSM drains over a valid/ready handshake.
//   - Sticky error status {crc, overflow, bad id}, RX packet counter and a
//     maskable, registered interrupt.
// Ports:
//   clk, n_rst                    clock, async active-low reset
//   bus_wen/bus_ren/bus_addr/
//   bus_wdata/bus_strobe          host access (write wins when both high,
//                                 strobe ignored)
//   bus_rdata/bus_error           combinational read data / access error
//   bus_request_stall             tied low
//   send_valid/send_id/
//   send_start_addr/send_ready    send queue head handshake to the TX FSM
//   rx_pkt_done, crc_error        single-cycle event pulses from the RX FSM
//   irq                           (sticky & irq_en) != 0, registered
module endpoint_ctrl #(
    parameter int NUM_MSGS     = 4,
    parameter int ADDR_WIDTH   = 9,
    parameter int SEND_Q_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        bus_wen,
    input  logic                        bus_ren,
    input  logic [31:0]                 bus_addr,
    input  logic [31:0]                 bus_wdata,
    input  logic [3:0]                  bus_strobe,
    output logic [31:0]                 bus_rdata,
    output logic                        bus_error,
    output logic                        bus_request_stall,
    output logic                        send_valid,
    output logic [$clog2(NUM_MSGS)-1:0] send_id,
    output logic [ADDR_WIDTH-1:0]       send_start_addr,
    input  logic                        send_ready,
    input  logic                        rx_pkt_done,
    input  logic                        crc_error,
    output logic                        irq
);
    localparam int IDW = $clog2(NUM_MSGS);
    localparam int PW  = (SEND_Q_DEPTH > 1) ? $clog2(SEND_Q_DEPTH) : 1;
    localparam int CW  = $clog2(SEND_Q_DEPTH + 1);

    localparam logic [31:0] BAD_DATA  = 32'hBAD1_BAD1;
    localparam logic [31:0] A_SEND    = 32'h0000_1004;
    localparam logic [31:0] A_STATUS  = 32'h0000_1008;
    localparam logic [31:0] A_RXCOUNT = 32'h0000_100C;
    localparam logic [31:0] A_IRQEN   = 32'h0000_1010;

    logic [NUM_MSGS-1:0][ADDR_WIDTH-1:0] pkt_start;
    logic [SEND_Q_DEPTH-1:0][IDW-1:0]    q_mem;
    logic [PW-1:0]                       head, tail;
    logic [CW-1:0]                       count;
    logic [2:0]                          sticky;
    logic [2:0]                          irq_en;
    logic [15:0]                         rx_count;

    // strobe is accepted for bus compatibility only
    logic unused_strobe;
    assign unused_strobe = ^bus_strobe;

    assign bus_request_stall = 1'b0;

    // ---------------- decode ----------------
    logic [31:0]    word_addr;
    logic           wr, rd;
    logic           hit_pkt, hit_send, hit_stat, hit_rxc, hit_irq, hit_any;
    logic [IDW-1:0] pkt_idx;

    assign word_addr = {bus_addr[31:2], 2'b00};
    assign wr        = bus_wen;
    assign rd        = bus_ren & ~bus_wen;
    assign hit_pkt   = (bus_addr[31:IDW+2] == '0);
    assign pkt_idx   = bus_addr[IDW+1:2];
    assign hit_send  = (word_addr == A_SEND);
    assign hit_stat  = (word_addr == A_STATUS);
    assign hit_rxc   = (word_addr == A_RXCOUNT);
    assign hit_irq   = (word_addr == A_IRQEN);
    assign hit_any   = hit_pkt | hit_send | hit_stat | hit_rxc | hit_irq;

    // ---------------- send queue control ----------------
    logic empty, full, pop, push, send_wr, bad_id, ovf;

    assign empty   = (count == '0);
    assign full    = (count == CW'(SEND_Q_DEPTH));
    assign pop     = send_valid & send_ready;
    assign send_wr = wr & hit_send;
    assign bad_id  = send_wr & (bus_wdata >= 32'(NUM_MSGS));
    // a full queue still accepts a push when the head leaves this cycle
    assign ovf     = send_wr & ~bad_id & full & ~pop;
    assign push    = send_wr & ~bad_id & ~ovf;

    assign send_valid      = ~empty;
    assign send_id         = q_mem[head];
    // address is looked up live so a slot rewrite before pop is honoured
    assign send_start_addr = pkt_start[send_id];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SEND_Q_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- read mux / error ----------------
    logic [31:0] status_word;

    always_comb begin
        status_word       = '0;
        status_word[0]    = empty;
        status_word[1]    = full;
        status_word[7:4]  = 4'(count);
        status_word[10:8] = sticky;
    end

    always_comb begin
        bus_rdata = BAD_DATA;
        bus_error = 1'b0;
        if (wr) begin
            if (!hit_any || bad_id || ovf)
                bus_error = 1'b1;
        end else if (rd) begin
            if (hit_pkt)
                bus_rdata = 32'(pkt_start[pkt_idx]);
            else if (hit_stat)
                bus_rdata = status_word;
            else if (hit_rxc)
                bus_rdata = {16'h0, rx_count};
            else if (hit_irq)
                bus_rdata = {29'h0, irq_en};
            else
                bus_error = 1'b1;   // TX_SEND is write-only, or unmapped
        end
    end

    // ---------------- state ----------------
    logic [2:0] sticky_set, sticky_clr;

    assign sticky_set = {crc_error, ovf, bad_id};
    assign sticky_clr = (wr & hit_stat) ? bus_wdata[10:8] : 3'b000;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_start <= '0;
            q_mem     <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            sticky    <= '0;
            irq_en    <= '0;
            rx_count  <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr && hit_pkt)
                pkt_start[pkt_idx] <= {bus_wdata[ADDR_WIDTH-1:2], 2'b00};
            if (wr && hit_irq)
                irq_en <= bus_wdata[2:0];

            if (push) begin
                q_mem[tail] <= bus_wdata[IDW-1:0];
                tail        <= ptr_inc(tail);
            end
            if (pop)
                head <= ptr_inc(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // set wins over a same-cycle W1C
            sticky <= (sticky & ~sticky_clr) | sticky_set;

            if (wr && hit_rxc)
                rx_count <= rx_pkt_done ? 16'd1 : 16'd0;
            else if (rx_pkt_done && rx_count != 16'hFFFF)
                rx_count <= rx_count + 16'd1;

            irq <= |(sticky & irq_en);
        end
    end
endmodule

// File: tb/tb_endpoint_ctrl.sv
module tb_endpoint_ctrl;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        bus_wen = 1'b0, bus_ren = 1'b0;
    logic [31:0] bus_addr = '0, bus_wdata = '0;
    logic [3:0]  bus_strobe = 4'hF;
    logic [31:0] bus_rdata;
    logic        bus_error, bus_request_stall;
    logic        send_valid;
    logic [1:0]  send_id;
    logic [8:0]  send_start_addr;
    logic        send_ready = 1'b0;
    logic        rx_pkt_done = 1'b0, crc_error = 1'b0;
    logic        irq;

    endpoint_ctrl #(.NUM_MSGS(4), .ADDR_WIDTH(9), .SEND_Q_DEPTH(4)) dut (
        .clk(clk), .n_rst(n_rst),
        .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
        .bus_rdata(bus_rdata), .bus_error(bus_error),
        .bus_request_stall(bus_request_stall),
        .send_valid(send_valid), .send_id(send_id),
        .send_start_addr(send_start_addr), .send_ready(send_ready),
        .rx_pkt_done(rx_pkt_done), .crc_error(crc_error), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        string       name;
    } bus_exp_t;

    bus_exp_t   bus_q[$];
    logic [1:0] send_q[$];
    logic [8:0] pkt_model [4];
    logic       bus_chk = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // bus response monitor
    always @(negedge clk) begin
        if (bus_chk) begin
            if (bus_q.size() == 0) begin
                chk("bus_q_underflow", 32'd1, 32'd0);
            end else begin
                bus_exp_t e;
                e = bus_q.pop_front();
                chk({e.name, "_err"}, 32'(bus_error), 32'(e.err));
                if (e.chk_rd) chk({e.name, "_rdata"}, bus_rdata, e.rdata);
            end
        end
    end

    // send handshake monitor
    always @(negedge clk) begin
        if (n_rst && send_valid && send_ready) begin
            if (send_q.size() == 0) begin
                chk("send_unexpected", 32'd1, 32'd0);
            end else begin
                logic [1:0] id;
                id = send_q.pop_front();
                chk("send_id", 32'(send_id), 32'(id));
                chk("send_addr", 32'(send_start_addr), 32'(pkt_model[id]));
            end
        end
    end

    task automatic acc(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] er,
                       input logic ee, input string nm);
        bus_exp_t e;
        e.rdata = er; e.err = ee; e.chk_rd = (r & ~w) | ee; e.name = nm;
        bus_q.push_back(e);
        bus_wen = w; bus_ren = r; bus_addr = a; bus_wdata = d; bus_chk = 1'b1;
        @(posedge clk); #1;
        bus_wen = 1'b0; bus_ren = 1'b0; bus_chk = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] er, input logic ee, input string nm);
        acc(1'b0, 1'b1, a, 32'h0, er, ee, nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic ee, input string nm);
        acc(1'b1, 1'b0, a, d, 32'hBAD1BAD1, ee, nm);
    endtask

    task automatic wr_pkt(input int i, input logic [31:0] d);
        wr(32'(4 * i), d, 1'b0, "wr_pkt");
        pkt_model[i] = d[8:0] & 9'h1FC;
    endtask

    task automatic send(input logic [31:0] id, input logic ee, input string nm);
        wr(32'h1004, id, ee, nm);
        if (!ee) send_q.push_back(id[1:0]);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        send_ready = 1'b1;
        for (int i = 0; i < 20 && send_q.size() != 0; i++) cyc(1);
        send_ready = 1'b0;
        chk(nm, 32'(send_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pkt_model[i] = '0;
        cyc(2);
        chk("rst_send_valid", 32'(send_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("stall", 32'(bus_request_stall), 32'd0);
        n_rst = 1'b1;
        cyc(1);

        // reset state of the map
        for (int i = 0; i < 4; i++) rd(32'(4 * i), 32'h0, 1'b0, "rst_pkt");
        rd(32'h1008, 32'h1, 1'b0, "rst_status");
        rd(32'h100C, 32'h0, 1'b0, "rst_rxcount");
        rd(32'h1010, 32'h0, 1'b0, "rst_irqen");
        rd(32'h1004, 32'hBAD1BAD1, 1'b1, "rd_txsend");
        rd(32'h2FFC, 32'hBAD1BAD1, 1'b1, "rd_unmapped");
        wr(32'h2000, 32'h5, 1'b1, "wr_unmapped");
        acc(1'b0, 1'b0, 32'h0, 32'h0, 32'hBAD1BAD1, 1'b0, "idle");
        // idle has no read request, so check rdata directly
        chk("idle_rdata", bus_rdata, 32'hBAD1BAD1);

        // pkt_start alignment and first send
        wr_pkt(2, 32'h107);
        rd(32'h8, 32'h104, 1'b0, "pkt2_rb");
        send(32'd2, 1'b0, "send2");
        chk("send_valid_n1", 32'(send_valid), 32'd1);
        chk("send_id_n1", 32'(send_id), 32'd2);
        chk("send_addr_n1", 32'(send_start_addr), 32'h104);
        cyc(1);
        chk("send_hold", 32'(send_valid), 32'd1);
        drain("drain_first");
        rd(32'h1008, 32'h1, 1'b0, "status_empty");

        // fill, overflow, push-with-pop
        wr_pkt(0, 32'h10);
        wr_pkt(1, 32'h24);
        wr_pkt(3, 32'h1FF);
        for (int i = 0; i < 4; i++) send(32'(i), 1'b0, "fill");
        rd(32'h1008, 32'h42, 1'b0, "status_full");
        send(32'd1, 1'b1, "overflow");
        rd(32'h1008, 32'h242, 1'b0, "status_ovf");
        wr(32'h1008, 32'h200, 1'b0, "w1c_ovf");
        send_ready = 1'b1;
        send(32'd1, 1'b0, "push_pop_full");
        drain("drain_order");
        rd(32'h1008, 32'h1, 1'b0, "status_drained");

        // slot rewrite before pop
        send(32'd3, 1'b0, "send3");
        wr_pkt(3, 32'h40);
        chk("live_addr", 32'(send_start_addr), 32'h40);
        drain("drain_rewrite");

        // bad id and interrupt
        send(32'd4, 1'b1, "bad_id");
        rd(32'h1008, 32'h101, 1'b0, "status_badid");
        wr(32'h1010, 32'h1, 1'b0, "irqen_wr");
        chk("irq_latency", 32'(irq), 32'd0);
        cyc(1);
        chk("irq_set", 32'(irq), 32'd1);
        rd(32'h1010, 32'h1, 1'b0, "irqen_rb");
        wr(32'h1008, 32'h100, 1'b0, "w1c_badid");
        cyc(1);
        chk("irq_clr", 32'(irq), 32'd0);
        rd(32'h1008, 32'h1, 1'b0, "status_clr");

        // RX counter saturation and clear/increment collision
        rx_pkt_done = 1'b1;
        cyc(70000);
        rx_pkt_done = 1'b0;
        rd(32'h100C, 32'hFFFF, 1'b0, "rx_sat");
        rx_pkt_done = 1'b1;
        wr(32'h100C, 32'h0, 1'b0, "rx_clr_inc");
        rx_pkt_done = 1'b0;
        rd(32'h100C, 32'h1, 1'b0, "rx_one");

        // crc set beats same-cycle W1C
        crc_error = 1'b1;
        wr(32'h1008, 32'h400, 1'b0, "crc_w1c");
        crc_error = 1'b0;
        rd(32'h1008, 32'h401, 1'b0, "crc_sticky");
        cyc(1);
        chk("irq_masked", 32'(irq), 32'd0);
        wr(32'h1008, 32'h400, 1'b0, "crc_clr");
        rd(32'h1008, 32'h1, 1'b0, "crc_cleared");

        // async reset with entries queued
        for (int i = 0; i < 3; i++) send(32'(i), 1'b0, "pre_rst");
        chk("pre_rst_valid", 32'(send_valid), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_async_valid", 32'(send_valid), 32'd0);
        bus_ren = 1'b1; bus_addr = 32'h1008;
        #1;
        chk("rst_async_status", bus_rdata, 32'h1);
        bus_ren = 1'b0;
        send_q.delete();
        for (int i = 0; i < 4; i++) pkt_model[i] = '0;
        cyc(1);
        n_rst = 1'b1;
        cyc(1);
        rd(32'h1010, 32'h0, 1'b0, "post_rst_irqen");
        rd(32'h0, 32'h0, 1'b0, "post_rst_pkt0");

        cyc(2);
        chk("bus_q_left", 32'(bus_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/endpoint_ctrl.md
# endpoint_ctrl

Parametrised control/status register block for the chiplet endpoint. It decodes host bus accesses to per-message packet start addresses and replaces the single-cycle send trigger with a queued send mechanism. A send FIFO is drained by the TX FSM over a valid/ready handshake. The block also keeps sticky error status, an RX packet counter and a maskable interrupt. It sits between the endpoint host bus and the TX/RX FSMs; cache windows are decoded outside this block.

## Interface
- NUM_MSGS, 4, number of message slots (power of two, ≥2)
- ADDR_WIDTH, 9, width of packet start address into TX cache
- SEND_Q_DEPTH, 4, send queue entries (2..15)
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- bus_wen / bus_ren  in  1  host write / read request (both high = write)
- bus_addr  in  32  host byte address
- bus_wdata  in  32  write data; bus_strobe in 4, ignored
- bus_rdata  out  32  read data, combinational
- bus_error  out  1  access error, combinational
- bus_request_stall  out  1  always 0
- send_valid  out  1  queue head valid
- send_id  out  $clog2(NUM_MSGS)  queue head message id
- send_start_addr  out  ADDR_WIDTH  pkt_start[send_id]
- send_ready  in  1  TX FSM accepts head
- rx_pkt_done  in  1  one-cycle pulse per completed RX packet
- crc_error  in  1  one-cycle pulse on RX CRC failure
- irq  out  1  (sticky & irq_en) != 0, registered

## Operation
- Map: 0x0+4i pkt_start[i] (i<NUM_MSGS), RW; write stores wdata[ADDR_WIDTH-1:0] & ~3.
- 0x1004 TX_SEND, WO: wdata<NUM_MSGS pushes wdata into queue; else bus_error=1, sticky[0] (bad id) set, no push. Full queue with no same-cycle pop: bus_error=1, sticky[1] (overflow) set, no push.
- 0x1008 STATUS: read [0] empty, [1] full, [7:4] count, [10:8] sticky {crc, overflow, bad id}. Write: W1C on wdata[10:8].
- 0x100C RX_COUNT: read 16-bit count, zero-extended; any write clears it. Increments on rx_pkt_done, saturates at 0xFFFF.
- 0x1010 IRQ_EN: RW, bits [2:0], masks sticky bits.
- crc_error pulse sets sticky[2].
- Reads of write-only or unmapped addresses, and writes to unmapped addresses: bus_error=1, rdata=0xBAD1BAD1. Idle bus: rdata=0xBAD1BAD1, error=0.
- Queue: circular FIFO, head/tail pointers wrap at SEND_Q_DEPTH; count width $clog2(SEND_Q_DEPTH+1). Pop when send_valid && send_ready. Push accepted when full if a pop occurs the same cycle. Push and pop on empty: no bypass; the entry appears next cycle.
- send_start_addr reads pkt_start live. A rewrite of a slot before pop changes the address presented.
- Simultaneous set and W1C on a sticky bit: set wins. rx_pkt_done with an RX_COUNT write: result is 1.

## Timing
- Reset: all pkt_start=0, queue empty (count 0), send_valid=0, send_id=0, sticky=0, irq_en=0, RX_COUNT=0, irq=0.
- All register writes are visible on the next clock edge; reads return current state in the same cycle.
- TX_SEND write in cycle N gives send_valid=1 in cycle N+1.
- Handshake: send_valid, once high, stays high and send_id holds until the pop. send_valid does not depend on send_ready.
- irq updates one cycle after sticky or irq_en changes.
- Asynchronous reset mid-operation clears the queue immediately. Any in-flight handshake is dropped.

## Test plan
- Reset, then read all map entries → pkt_start=0, STATUS=0x1, RX_COUNT=0; unmapped 0x2FFC read → error=1, rdata=0xBAD1BAD1.
- Write 0x107 to pkt_start[2], read back → 0x104. Send id 2 → next cycle send_valid=1, send_id=2, send_start_addr=0x104.
- Push ids 0,1,2,3 with send_ready=0 → STATUS full=1, count=4. Fifth push → error=1, sticky[1]=1. Push while send_ready=1 → accepted, order preserved.
- Write TX_SEND=4 (NUM_MSGS=4) → error=1, STATUS bit8=1, no push. IRQ_EN=0x1 → irq=1 next cycle. W1C 0x100 → irq=0.
- 70000 rx_pkt_done pulses → RX_COUNT=0xFFFF. Write plus pulse same cycle → RX_COUNT=1.
- crc_error pulse with a W1C of bit 10 in the same cycle → bit 10 stays 1. Assert n_rst with 3 entries queued → send_valid=0 and count=0 immediately.
